cpu_run_ctrl: RTL and testbench

Run controller for the 14-bit-address single-port-RAM CPU. It holds the CPU in reset, loads a program image from a host word stream into RAM starting at address 0, and then releases the CPU. It ends the run on a halt-mailbox write or a cycle-limit watchdog, and then gives the host read access to RAM. It owns the single RAM port and multiplexes it between the loader, the CPU and host readback.

---
 rtl/cpu_sys_pkg.sv | 18 +
 rtl/cpu_run_ctrl_if.sv | 27 ++
 rtl/cpu_run_ctrl_ram_port_mux.sv | 52 +++++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sys_pkg.sv
// Shared types and constants for the run controller and the benches that build program images.
package cpu_sys_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  // Opcode fields in instruction bits [31:28].
  localparam logic [3:0] CPi  = 4'b1001;
  localparam logic [3:0] BZJi = 4'b1101;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host-side load stream and RAM readback channel of the run controller.
interface cpu_run_ctrl_if
  import cpu_sys_pkg::*;
#(
  parameter int unsigned SIZE = ADDR_W
) ();

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              rd_req;
  logic [SIZE-1:0]   rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output ld_valid, ld_data, ld_last, rd_req, rd_addr,
    input  ld_ready, rd_valid, rd_data
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, rd_req, rd_addr,
    output ld_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/cpu_run_ctrl_ram_port_mux.sv
// Combinational owner of the single RAM port: loader, CPU or host readback.
module ram_port_mux
  import cpu_sys_pkg::*;
#(
  parameter int unsigned SIZE = ADDR_W
) (
  input  run_state_t        state,
  input  logic              start,
  input  logic              rd_req,
  input  logic [SIZE-1:0]   rd_addr,
  input  logic              ld_hs,
  input  logic [SIZE-1:0]   ld_ptr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cpu_wrEn,
  input  logic [SIZE-1:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              ram_wrEn,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rd_fire
);

  always_comb begin
    ram_wrEn  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    rd_fire   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        // A start in the same cycle takes priority and drops the read.
        if (rd_req && !start) begin
          ram_addr = rd_addr;
          rd_fire  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ld_hs) begin
          ram_wrEn  = 1'b1;
          ram_addr  = ld_ptr;
          ram_wdata = ld_data;
        end
      end
      ST_RUN: begin
        ram_wrEn  = cpu_wrEn;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program image into RAM, runs the CPU until halt or watchdog, then serves readback.
module cpu_run_ctrl
  import cpu_sys_pkg::*;
#(
  parameter int unsigned     SIZE       = ADDR_W,
  parameter logic [SIZE-1:0] HALT_ADDR  = SIZE'(14'h3FFF),
  parameter int unsigned     MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cpu_run_ctrl_if.slave     host,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] halt_code,
  output logic [31:0]       cycles,
  output logic              cpu_rst,
  input  logic              cpu_wrEn,
  input  logic [SIZE-1:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_wrEn,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  run_state_t        state, state_nxt;
  logic [SIZE-1:0]   ptr, ptr_nxt;
  logic              ld_ready_q, ld_ready_nxt;
  logic              rd_valid_q;
  logic              busy_nxt, done_nxt, timeout_nxt;
  logic [DATA_W-1:0] halt_nxt;
  logic [31:0]       cycles_nxt;
  logic              ld_hs, rd_fire, halt_hit;

  assign ld_hs    = host.ld_valid && ld_ready_q;
  assign halt_hit = cpu_wrEn && (cpu_addr == HALT_ADDR);
  assign cpu_rst  = rst || (state != ST_RUN);
  assign cpu_rdata = ram_rdata;

  assign host.ld_ready = ld_ready_q;
  assign host.rd_valid = rd_valid_q;
  // RAM data arrives in the cycle after the address, i.e. alongside rd_valid.
  assign host.rd_data  = rd_valid_q ? ram_rdata : '0;

  ram_port_mux #(.SIZE(SIZE)) u_mux (
    .state     (state),
    .start     (start),
    .rd_req    (host.rd_req),
    .rd_addr   (host.rd_addr),
    .ld_hs     (ld_hs),
    .ld_ptr    (ptr),
    .ld_data   (host.ld_data),
    .cpu_wrEn  (cpu_wrEn),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .ram_wrEn  (ram_wrEn),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .rd_fire   (rd_fire)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    done_nxt    = done;
    timeout_nxt = timeout;
    halt_nxt    = halt_code;
    cycles_nxt  = cycles;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_LOAD;
          ptr_nxt     = '0;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          halt_nxt    = '0;
          cycles_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (ld_hs) begin
          ptr_nxt = ptr + SIZE'(1);
          // The top address is the last slot; leave LOAD rather than wrap.
          if (host.ld_last || (ptr == {SIZE{1'b1}})) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cycles_nxt = cycles + 32'd1;
        if (halt_hit) begin
          halt_nxt  = cpu_data;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (cycles_nxt == 32'(MAX_CYCLES)) begin
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    ld_ready_nxt = (state_nxt == ST_LOAD);
    busy_nxt     = (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ld_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      halt_code  <= '0;
      cycles     <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      ld_ready_q <= ld_ready_nxt;
      rd_valid_q <= rd_fire;
      busy       <= busy_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      halt_code  <= halt_nxt;
      cycles     <= cycles_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with a behavioural RAM and directed CPU bus activity.
module tb_cpu_run_ctrl;
  import cpu_sys_pkg::*;

  localparam int unsigned SIZE = ADDR_W;
  localparam logic [SIZE-1:0] HALT = 14'h3FFF;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, timeout, cpu_rst;
  logic [31:0] halt_code, cycles, cpu_rdata, ram_wdata, cpu_data;
  logic [31:0] ram_rdata = '0;
  logic cpu_wrEn, ram_wrEn;
  logic [SIZE-1:0] cpu_addr, ram_addr;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.SIZE(SIZE)) host ();

  cpu_run_ctrl #(.SIZE(SIZE), .HALT_ADDR(HALT), .MAX_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .host(host),
    .busy(busy), .done(done), .timeout(timeout), .halt_code(halt_code),
    .cycles(cycles), .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_rdata(cpu_rdata), .ram_wrEn(ram_wrEn),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [0:(1<<SIZE)-1];
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         mon_w;
  logic [31:0] mon_r;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [SIZE-1:0] lp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write and every rd_valid must match the next queued expectation.
  always @(negedge clk) begin
    if (ram_wrEn) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ram_write: addr %h data %h, no write expected", ram_addr, ram_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("ram_wr_addr", 32'(ram_addr), 32'(mon_w.addr));
        chk("ram_wr_data", ram_wdata, mon_w.data);
      end
    end
    if (host.rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rd_valid: data %h, no read expected", host.rd_data);
      end else begin
        mon_r = exp_rd.pop_front();
        chk("rd_data", host.rd_data, mon_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    lp = '0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    exp_wr.push_back({lp, d});
    lp = lp + SIZE'(1);
    host.ld_valid = 1'b1;
    host.ld_data  = d;
    host.ld_last  = last;
    tick();
    host.ld_valid = 1'b0;
    host.ld_last  = 1'b0;
    host.ld_data  = '0;
  endtask

  task automatic cpu_write(input logic [SIZE-1:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
    cpu_wrEn = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    tick();
    cpu_wrEn = 1'b0;
    cpu_data = '0;
  endtask

  task automatic host_read(input logic [SIZE-1:0] a, input logic [31:0] d);
    exp_rd.push_back(d);
    host.rd_req  = 1'b1;
    host.rd_addr = a;
    tick();
    host.rd_req  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic t,
                            input logic [31:0] h, input logic [31:0] c);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
    chk({tag, "_halt_code"}, halt_code, h);
    chk({tag, "_cycles"}, cycles, c);
  endtask

  logic [31:0] img_halt, img_loop;

  initial begin
    for (int i = 0; i < (1 << SIZE); i++) mem[i] = '0;
    img_halt = {CPi, 14'h3FFF, 14'd42};
    img_loop = {BZJi, 14'd1, 14'd0};
    rst = 1'b1; start = 1'b0;
    host.ld_valid = 1'b0; host.ld_data = '0; host.ld_last = 1'b0;
    host.rd_req = 1'b0; host.rd_addr = '0;
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_data = '0;
    lp = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk_status("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ld_ready", 32'(host.ld_ready), 32'd0);
    chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);

    // Test 1: halt run, with an ignored rd_req in RUN cycle 1
    do_start();
    chk("t1_ld_ready_load", 32'(host.ld_ready), 32'd1);
    load_word(img_halt, 1'b1);
    chk("t1_cpu_rst_run", 32'(cpu_rst), 32'd0);
    chk("t1_busy_run", 32'(busy), 32'd1);
    host.rd_req = 1'b1; host.rd_addr = HALT; cpu_addr = 14'd5;
    #1;
    chk("t3_run_ram_addr_cpu", 32'(ram_addr), 32'd5);
    tick();
    host.rd_req = 1'b0;
    tick();
    cpu_write(HALT, 32'd42);
    chk_status("t1", 1'b1, 1'b0, 32'd42, 32'd3);
    chk("t1_cpu_rst_done", 32'(cpu_rst), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Test 3: readback of mailbox and image word
    host_read(HALT, 32'd42);
    host_read(14'd0, img_halt);
    tick();

    // Test 2: watchdog
    do_start();
    chk_status("t2_start_clear", 1'b0, 1'b0, 32'd0, 32'd0);
    load_word(img_loop, 1'b0);
    load_word(32'h0, 1'b1);
    cpu_addr = '0;
    repeat (15) tick();
    chk("t2_done_before_limit", 32'(done), 32'd0);
    chk("t2_cycles_15", cycles, 32'd15);
    tick();
    chk_status("t2", 1'b1, 1'b1, 32'd0, 32'd16);
    host_read(14'd0, img_loop);
    tick();

    // Test 4: load backpressure
    chk("t4_ld_ready_done", 32'(host.ld_ready), 32'd0);
    do_start();
    load_word(32'hA, 1'b0);
    tick();
    load_word(32'hB, 1'b0);
    load_word(32'hC, 1'b1);
    chk("t4_ld_ready_run", 32'(host.ld_ready), 32'd0);
    cpu_write(HALT, 32'd7);
    chk_status("t4", 1'b1, 1'b0, 32'd7, 32'd1);
    host_read(14'd0, 32'hA);
    host_read(14'd1, 32'hB);
    host_read(14'd2, 32'hC);
    tick();

    // Test 5: reset mid-RUN, then a fresh load
    do_start();
    load_word(img_loop, 1'b0);
    load_word(32'h0, 1'b1);
    repeat (4) tick();
    chk("t5_cycles_4", cycles, 32'd4);
    rst = 1'b1;
    #1;
    chk("t5_cpu_rst_same_cycle", 32'(cpu_rst), 32'd1);
    tick();
    rst = 1'b0;
    chk_status("t5_after_rst", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ld_ready", 32'(host.ld_ready), 32'd0);
    chk("t5_cpu_rst_idle", 32'(cpu_rst), 32'd1);
    do_start();
    load_word(32'h12345678, 1'b1);
    cpu_write(HALT, 32'd99);
    chk_status("t5_rerun", 1'b1, 1'b0, 32'd99, 32'd1);
    host_read(14'd0, 32'h12345678);
    tick();

    // Test 6: halt coincides with the watchdog limit; then start+rd_req together
    do_start();
    load_word(img_halt, 1'b1);
    repeat (15) tick();
    cpu_write(HALT, 32'd42);
    chk_status("t6", 1'b1, 1'b0, 32'd42, 32'd16);
    start = 1'b1; host.rd_req = 1'b1; host.rd_addr = '0;
    #1;
    chk("t6_no_ram_write", 32'(ram_wrEn), 32'd0);
    tick();
    start = 1'b0; host.rd_req = 1'b0;
    chk("t6_busy_load", 32'(busy), 32'd1);
    chk("t6_ld_ready_load", 32'(host.ld_ready), 32'd1);
    chk("t6_done_cleared", 32'(done), 32'd0);
    tick(); tick();

    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: bench did not finish, limit exceeded");
    $fatal(1);
  end

endmodule
